// File: rtl/enc_sequencer.sv
// Top-level control FSM for one LWE encryption pass: looper reset/start, drain, b-memory readout.
// Optional ENC_SEQ_WATCHDOG_EN bounds the time spent waiting for the looper.
module enc_sequencer #(
    parameter int DEPTH    = 100,
    parameter int K        = 500,
    parameter int PIPE_LAT = 4,
    parameter int WD_SLACK = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        key_loaded,
    input  logic        abort_in,
    output logic        looper_rst,
    output logic        begin_enc,
    input  logic        looper_done,
    output logic        mem_sel,
    output logic [12:0] rd_addr,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic        rd_last,
    output logic        busy,
    output logic        done_pulse,
    output logic        err_out
);

    localparam int HALF_DEPTH = DEPTH / 2;
    localparam int DW         = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1;
    localparam logic [12:0]   LAST_ADDR  = 13'(HALF_DEPTH - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);

    if (HALF_DEPTH < 1 || HALF_DEPTH > 8192) begin : g_bad_depth
        $error("enc_sequencer: HALF_DEPTH must be within 1..8192");
    end
    if (K < 1 || PIPE_LAT < 0 || WD_SLACK < 0) begin : g_bad_param
        $error("enc_sequencer: K must be positive, PIPE_LAT and WD_SLACK non-negative");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LRST,
        S_START,
        S_RUN,
        S_DRAIN,
        S_READ,
        S_FIN
    } state_t;

    state_t        state_reg;
    logic          looper_rst_reg;
    logic          begin_enc_reg;
    logic          mem_sel_reg;
    logic          rd_valid_reg;
    logic          rd_last_reg;
    logic [12:0]   rd_addr_reg;
    logic          busy_reg;
    logic          done_reg;
    logic          err_reg;
    logic [DW-1:0] drain_cnt_reg;

`ifdef ENC_SEQ_WATCHDOG_EN
    localparam logic [31:0] WD_LIMIT = 32'(K * HALF_DEPTH * HALF_DEPTH + WD_SLACK);
    logic [31:0] wd_cnt_reg;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg      <= S_IDLE;
            looper_rst_reg <= 1'b0;
            begin_enc_reg  <= 1'b0;
            mem_sel_reg    <= 1'b0;
            rd_valid_reg   <= 1'b0;
            rd_last_reg    <= 1'b0;
            rd_addr_reg    <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            drain_cnt_reg  <= '0;
`ifdef ENC_SEQ_WATCHDOG_EN
            wd_cnt_reg     <= '0;
`endif
        end else begin
            looper_rst_reg <= 1'b0;
            begin_enc_reg  <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            // Abort outranks every other event in the same cycle.
            if (state_reg != S_IDLE && abort_in) begin
                state_reg      <= S_IDLE;
                looper_rst_reg <= 1'b1;
                mem_sel_reg    <= 1'b0;
                rd_valid_reg   <= 1'b0;
                rd_last_reg    <= 1'b0;
                rd_addr_reg    <= '0;
                busy_reg       <= 1'b0;
                drain_cnt_reg  <= '0;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (req_valid) begin
                            if (key_loaded) begin
                                state_reg      <= S_LRST;
                                looper_rst_reg <= 1'b1;
                                busy_reg       <= 1'b1;
                            end else begin
                                err_reg <= 1'b1;
                            end
                        end
                    end
                    S_LRST: begin
                        state_reg     <= S_START;
                        begin_enc_reg <= 1'b1;
                        mem_sel_reg   <= 1'b0;
                    end
                    S_START: begin
                        state_reg <= S_RUN;
`ifdef ENC_SEQ_WATCHDOG_EN
                        wd_cnt_reg <= '0;
`endif
                    end
                    S_RUN: begin
                        if (looper_done) begin
                            if (PIPE_LAT == 0) begin
                                state_reg    <= S_READ;
                                mem_sel_reg  <= 1'b1;
                                rd_valid_reg <= 1'b1;
                                rd_addr_reg  <= '0;
                                rd_last_reg  <= (LAST_ADDR == 13'd0);
                            end else begin
                                state_reg     <= S_DRAIN;
                                drain_cnt_reg <= '0;
                            end
                        end
`ifdef ENC_SEQ_WATCHDOG_EN
                        else if (wd_cnt_reg == WD_LIMIT - 32'd1) begin
                            state_reg      <= S_IDLE;
                            err_reg        <= 1'b1;
                            looper_rst_reg <= 1'b1;
                            busy_reg       <= 1'b0;
                        end else begin
                            wd_cnt_reg <= wd_cnt_reg + 32'd1;
                        end
`endif
                    end
                    S_DRAIN: begin
                        if (drain_cnt_reg == DRAIN_LAST) begin
                            state_reg    <= S_READ;
                            mem_sel_reg  <= 1'b1;
                            rd_valid_reg <= 1'b1;
                            rd_addr_reg  <= '0;
                            rd_last_reg  <= (LAST_ADDR == 13'd0);
                        end else begin
                            drain_cnt_reg <= drain_cnt_reg + DW'(1);
                        end
                    end
                    S_READ: begin
                        if (rd_ready) begin
                            if (rd_last_reg) begin
                                state_reg    <= S_FIN;
                                rd_valid_reg <= 1'b0;
                                rd_last_reg  <= 1'b0;
                                rd_addr_reg  <= '0;
                                done_reg     <= 1'b1;
                            end else begin
                                rd_addr_reg <= rd_addr_reg + 13'd1;
                                rd_last_reg <= (rd_addr_reg + 13'd1 == LAST_ADDR);
                            end
                        end
                    end
                    S_FIN: begin
                        state_reg   <= S_IDLE;
                        mem_sel_reg <= 1'b0;
                        busy_reg    <= 1'b0;
                    end
                    default: begin
                        state_reg    <= S_IDLE;
                        mem_sel_reg  <= 1'b0;
                        rd_valid_reg <= 1'b0;
                        rd_last_reg  <= 1'b0;
                        rd_addr_reg  <= '0;
                        busy_reg     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign req_ready  = (state_reg == S_IDLE) && key_loaded;
    assign looper_rst = looper_rst_reg;
    assign begin_enc  = begin_enc_reg;
    assign mem_sel    = mem_sel_reg;
    assign rd_addr    = rd_addr_reg;
    assign rd_valid   = rd_valid_reg;
    assign rd_last    = rd_last_reg;
    assign busy       = busy_reg;
    assign done_pulse = done_reg;
    assign err_out    = err_reg;

endmodule

// File: tb/tb_enc_sequencer.sv
// Randomized bench for enc_sequencer with a timestamp-based pass model and a simple looper model.
module tb_enc_sequencer;

    localparam int DEPTH    = 4;
    localparam int K        = 2;
    localparam int PIPE_LAT = 4;
    localparam int WD_SLACK = 16;
    localparam int H        = DEPTH / 2;
    localparam int WD_LIMIT = K * H * H + WD_SLACK;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        key_loaded = 1'b0;
    logic        abort_in = 1'b0;
    logic        looper_rst;
    logic        begin_enc;
    logic        looper_done = 1'b0;
    logic        mem_sel;
    logic [12:0] rd_addr;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic        rd_last;
    logic        busy;
    logic        done_pulse;
    logic        err_out;

    enc_sequencer #(
        .DEPTH(DEPTH), .K(K), .PIPE_LAT(PIPE_LAT), .WD_SLACK(WD_SLACK)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .req_valid(req_valid), .req_ready(req_ready),
        .key_loaded(key_loaded), .abort_in(abort_in), .looper_rst(looper_rst),
        .begin_enc(begin_enc), .looper_done(looper_done), .mem_sel(mem_sel),
        .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
        .busy(busy), .done_pulse(done_pulse), .err_out(err_out)
    );

    initial forever #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Pass model: a pass is described by when it was accepted, when the looper finished,
    // how many words were taken and when the last one went.
    int m_active = 0;
    int t_acc = -100, t_done = -1, t_fin = -1, words = 0;
    bit e_lrst, e_beg, e_msel, e_rdv, e_last, e_busy, e_done, e_err;
    int e_addr;

    // Looper model: done rises looper_len cycles after begin_enc, sticky until reset.
    int looper_len = 8;
    int lp_run = 0, lp_cnt = 0;

    int obs_err_n, obs_err_cyc, obs_done_n, obs_done_cyc, obs_lrst_n, obs_lrst_first, obs_rd_n;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        int  n = cyc;
        int  prev = cyc - 1;
        bit  err_now = 1'b0;
        bit  lr_ab = 1'b0;
        bit  in_read;
        if (rst_in) begin
            m_active = 0; t_acc = -100; t_done = -1; t_fin = -1; words = 0;
        end else if (m_active == 0) begin
            if (req_valid && key_loaded) begin
                m_active = 1; t_acc = n; t_done = -1; t_fin = -1; words = 0;
            end else if (req_valid) begin
                err_now = 1'b1;
            end
        end else if (abort_in) begin
            m_active = 0; lr_ab = 1'b1;
        end else begin
            if (t_fin >= 0 && prev == t_fin) begin
                m_active = 0;
            end else if (t_done < 0 && prev >= t_acc + 2) begin
                if (looper_done) t_done = n;
`ifdef ENC_SEQ_WATCHDOG_EN
                else if (prev - (t_acc + 2) == WD_LIMIT - 1) begin
                    m_active = 0; err_now = 1'b1; lr_ab = 1'b1;
                end
`endif
            end else if (t_done >= 0 && prev >= t_done + PIPE_LAT && t_fin < 0 && rd_ready) begin
                words++;
                if (words == H) t_fin = n;
            end
        end
        in_read = (m_active != 0) && t_done >= 0 && n >= t_done + PIPE_LAT && t_fin < 0;
        e_busy  = (m_active != 0);
        e_lrst  = lr_ab || (m_active != 0 && n == t_acc);
        e_beg   = (m_active != 0) && n == t_acc + 1;
        e_rdv   = in_read;
        e_addr  = in_read ? words : 0;
        e_last  = in_read && words == H - 1;
        e_done  = (m_active != 0) && t_fin >= 0 && n == t_fin;
        e_msel  = (m_active != 0) && t_done >= 0 && n >= t_done + PIPE_LAT;
        e_err   = err_now;
    endtask

    task automatic compare();
        check("busy", int'(busy), int'(e_busy));
        check("req_ready", int'(req_ready), int'(!e_busy && key_loaded));
        check("looper_rst", int'(looper_rst), int'(e_lrst));
        check("begin_enc", int'(begin_enc), int'(e_beg));
        check("mem_sel", int'(mem_sel), int'(e_msel));
        check("rd_valid", int'(rd_valid), int'(e_rdv));
        check("rd_addr", int'(rd_addr), e_addr);
        check("rd_last", int'(rd_last), int'(e_last));
        check("done_pulse", int'(done_pulse), int'(e_done));
        check("err_out", int'(err_out), int'(e_err));
    endtask

    task automatic observe();
        if (err_out) begin obs_err_n++; obs_err_cyc = cyc; end
        if (done_pulse) begin obs_done_n++; obs_done_cyc = cyc; end
        if (looper_rst) begin
            obs_lrst_n++;
            if (obs_lrst_first < 0) obs_lrst_first = cyc;
        end
        if (rd_valid) obs_rd_n++;
    endtask

    task automatic looper_step();
        if (rst_in || looper_rst) begin
            lp_run = 0; lp_cnt = 0; looper_done = 1'b0;
        end else if (begin_enc) begin
            lp_run = 1; lp_cnt = 0;
        end else if (lp_run != 0 && !looper_done) begin
            lp_cnt++;
            if (lp_cnt == looper_len) looper_done = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        cyc++;
        model_step();
        #1;
        compare();
        observe();
        #1;
        looper_step();
    endtask

    task automatic obs_clear();
        obs_err_n = 0; obs_err_cyc = -1; obs_done_n = 0; obs_done_cyc = -1;
        obs_lrst_n = 0; obs_lrst_first = -1; obs_rd_n = 0;
    endtask

    task automatic pulse_req();
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int i = 0;
        do begin
            tick();
            i++;
        end while (busy && i < budget);
        check("idle_timeout", int'(busy), 0);
    endtask

    task automatic wait_addr1(input int budget);
        int i = 0;
        while (!(rd_valid && rd_addr == 13'd1) && i < budget) begin
            tick();
            i++;
        end
        check("addr1_timeout", int'(rd_valid && rd_addr == 13'd1), 1);
    endtask

    initial begin
        obs_clear();
        repeat (3) tick();
        rst_in = 1'b0;
        tick();
        check("reset_busy", int'(busy), 0);

        // Request without key: single error pulse, nothing started.
        obs_clear();
        pulse_req();
        repeat (3) tick();
        check("nokey_err_n", obs_err_n, 1);
        check("nokey_lrst_n", obs_lrst_n, 0);

        // Nominal pass.
        key_loaded = 1'b1; rd_ready = 1'b1; looper_len = 8;
        obs_clear();
        pulse_req();
        wait_idle(100);
        check("t1_done_n", obs_done_n, 1);
        check("t1_lrst_to_done", obs_done_cyc - obs_lrst_first, 16);
        check("t1_rd_cycles", obs_rd_n, 2);
        check("t1_lrst_n", obs_lrst_n, 1);

        // Readout backpressure on the second word.
        obs_clear();
        pulse_req();
        wait_addr1(60);
        rd_ready = 1'b0;
        repeat (5) tick();
        rd_ready = 1'b1;
        wait_idle(20);
        check("t2_rd_cycles", obs_rd_n, 7);
        check("t2_done_n", obs_done_n, 1);

        // Abort coincident with looper_done.
        obs_clear();
        pulse_req();
        begin
            int i = 0;
            while (!looper_done && i < 40) begin tick(); i++; end
        end
        check("t4_done_timeout", int'(looper_done), 1);
        abort_in = 1'b1;
        tick();
        abort_in = 1'b0;
        repeat (10) tick();
        check("t4_done_n", obs_done_n, 0);
        check("t4_rd_cycles", obs_rd_n, 0);
        check("t4_lrst_n", obs_lrst_n, 2);

        // Reset during readout, then a clean pass.
        obs_clear();
        pulse_req();
        wait_addr1(60);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        check("t5_busy", int'(busy), 0);
        check("t5_mem_sel", int'(mem_sel), 0);
        obs_clear();
        pulse_req();
        wait_idle(100);
        check("t5_done_n", obs_done_n, 1);
        check("t5_rd_cycles", obs_rd_n, 2);

        // Looper that never finishes.
        looper_len = -1;
        obs_clear();
        pulse_req();
`ifdef ENC_SEQ_WATCHDOG_EN
        repeat (60) tick();
        check("t6_wd_err_n", obs_err_n, 1);
        check("t6_wd_latency", obs_err_cyc - obs_lrst_first, WD_LIMIT + 2);
        check("t6_wd_lrst_n", obs_lrst_n, 2);
`else
        repeat (1000) tick();
        check("t6_still_busy", int'(busy), 1);
        abort_in = 1'b1;
        tick();
        abort_in = 1'b0;
        tick();
`endif

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if (!busy) looper_len = 1 + int'($urandom_range(0, 11));
            req_valid  = ($urandom_range(0, 7) == 0);
            key_loaded = ($urandom_range(0, 9) != 0);
            rd_ready   = ($urandom_range(0, 1) == 1);
            abort_in   = ($urandom_range(0, 59) == 0);
            rst_in     = ($urandom_range(0, 399) == 0);
            tick();
        end
        req_valid = 1'b0; abort_in = 1'b0; rst_in = 1'b0;
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/enc_sequencer.md
Name: enc_sequencer

Overview:
Top-level control FSM for one LWE encryption pass.
- Accepts an encrypt request and resets the encryption address looper.
- Fires the looper's start pulse, waits for its done, then drains the MAC/b-write pipeline.
- Streams the HALF_DEPTH result words of b memory out through a valid/ready read port.
- Owns the b-memory port mux: looper during encryption, readout afterwards.

Parameters:
DEPTH, 100, ring dimension; HALF_DEPTH = DEPTH/2 b words per pass
K, 500, outer loop count of the looper
PIPE_LAT, 4, cycles from looper done to last b write landing in memory
WD_SLACK, 16, extra cycles allowed by the watchdog (optional feature only)

Ports:
clk_in  in  1  system clock
rst_in  in  1  synchronous active-high reset
req_valid  in  1  encrypt request
req_ready  out  1  high when a request can be accepted
key_loaded  in  1  level; s/A memories populated
abort_in  in  1  abandon current operation
looper_rst  out  1  one-cycle reset pulse to looper
begin_enc  out  1  one-cycle start pulse to looper
looper_done  in  1  looper done (sticky until looper reset)
mem_sel  out  1  0 = looper owns b port, 1 = readout owns b port
rd_addr  out  13  b readout address
rd_valid  out  1  rd_addr valid
rd_ready  in  1  consumer accepts rd_addr
rd_last  out  1  qualifies final readout word
busy  out  1  high in any state other than IDLE
done_pulse  out  1  one cycle on pass completion
err_out  out  1  one-cycle error pulse

Behaviour:
- Reset values: state IDLE; all outputs 0 except req_ready = key_loaded (combinational).
- States:
  - IDLE: req_ready = key_loaded. On req_valid && key_loaded → LRST. On req_valid && !key_loaded → err_out pulse, stay IDLE.
  - LRST: looper_rst = 1 for exactly one cycle → START.
  - START: begin_enc = 1 for exactly one cycle; mem_sel = 0 → RUN.
  - RUN: wait for looper_done = 1 → DRAIN. The looper's done is sticky, so it is sampled only in RUN.
  - DRAIN: count PIPE_LAT cycles (0 .. PIPE_LAT-1) → READ. If PIPE_LAT = 0, go straight to READ.
  - READ: mem_sel = 1; rd_valid = 1; rd_addr starts at 0.
    - Advance on rd_valid && rd_ready; hold rd_addr while rd_ready = 0.
    - rd_last = 1 when rd_addr == HALF_DEPTH-1.
    - Accept with rd_last → FIN.
  - FIN: done_pulse = 1 for one cycle → IDLE.
- busy = 1 in every state except IDLE. mem_sel returns to 0 in IDLE.
- Handshakes:
  - A request is accepted only in the cycle where req_valid && req_ready.
  - Requests arriving in any other state are ignored, with no error.
  - rd_addr/rd_valid are registered outputs and stable while stalled.
- abort_in in any non-IDLE state, on the next cycle: state → IDLE, looper_rst pulses, rd_valid drops, no done_pulse, no err_out.
  - abort_in wins over looper_done or a rd handshake in the same cycle.
  - abort_in in IDLE has no effect.
- rst_in mid-operation: all state and outputs return to reset values the next cycle. No looper_rst pulse is generated; the looper shares rst_in.
- Widths: rd_addr is 13 bits, zero-extended; HALF_DEPTH ≤ 8192 is enforced by elaboration-time assertion. The drain counter is sized by $clog2(PIPE_LAT+1).
- Nominal pass length: the looper issues K·HALF_DEPTH² addresses between begin_enc and looper_done.

Optional Feature:
- Macro: ENC_SEQ_WATCHDOG_EN.
- With the macro:
  - A 32-bit cycle counter clears on entering RUN.
  - If it reaches K·HALF_DEPTH² + WD_SLACK without looper_done, the FSM exits RUN: err_out pulses, looper_rst pulses, state → IDLE, no readout.
- Without the macro: no counter; RUN waits indefinitely.

Test Plan:
1. DEPTH=4, K=2, key_loaded=1, one-cycle req_valid → looper_rst at cycle +1, begin_enc at +2, RUN until looper_done (model asserts after 8 addresses), DRAIN 4 cycles, rd_addr 0,1 with rd_last on 1, done_pulse once, busy low after.
2. Readout backpressure: rd_ready low for 5 cycles at rd_addr=1 → rd_addr/rd_valid/rd_last held stable; completes on the first rd_ready=1.
3. req_valid with key_loaded=0 → err_out single pulse, req_ready=0, no looper_rst/begin_enc, state stays IDLE.
4. abort_in asserted in the same cycle as looper_done → IDLE next cycle, looper_rst pulse, no DRAIN/READ, no done_pulse.
5. rst_in asserted during READ at rd_addr=1 → next cycle all outputs 0, mem_sel=0; a new request then runs a full pass correctly.
6. ENC_SEQ_WATCHDOG_EN defined, DEPTH=4, K=2, WD_SLACK=16, looper_done never asserted → err_out exactly 24 cycles after entering RUN, looper_rst pulse, IDLE; macro undefined → still busy after 1000 cycles.
